// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl - HI/LO multiply/divide sequencer for the EX stage.
//
// Accepts mult/multu/div/divu from EX, computes the 64-bit result in the
// issue cycle into a pending register, then models the fixed unit latency
// with a countdown before committing to HI/LO. mthi/mtlo write HI/LO
// directly when the unit is idle. Raises a stall request that holds any
// HI/LO-class instruction in ID while the unit is occupied.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-high reset, clears all state
//   op_valid     in   EX instruction is a HI/LO-class op
//   op     [2:0] in   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 ignored
//   flush        in   EX instruction cancelled; suppresses op_valid
//   rs_data[31:0] in  forwarded rs operand
//   rt_data[31:0] in  forwarded rt operand
//   mult_type_id in   ID holds a HI/LO-class instruction
//   busy         out  unit occupied (registered)
//   stall_req    out  hold ID (combinational, covers the issue cycle)
//   done         out  one-cycle pulse the cycle after a mult/div commit
//   hi    [31:0] out  HI register
//   lo    [31:0] out  LO register
module muldiv_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic        flush,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        mult_type_id,
  output logic        busy,
  output logic        stall_req,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic        done_q, done_d;

  logic accept;
  logic is_muldiv;
  logic last_cycle;

  assign is_muldiv  = ~op[2];
  assign accept     = op_valid & ~flush & (state_q == IDLE);
  assign last_cycle = (cnt_q <= 4'd1);

  // ---------------- arithmetic ----------------
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               dvd_neg, dvs_neg;
  logic        [31:0] dvd_mag, dvs_mag, dvs_safe;
  logic        [31:0] quo_mag, rem_mag, quo, rem;
  logic        [63:0] result;

  assign prod_s = $signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data});
  assign prod_u = {32'd0, rs_data} * {32'd0, rt_data};

  // Signed divide runs on magnitudes through the same unsigned divider.
  // 0x80000000 / -1 falls out naturally: magnitude 0x80000000, re-negated
  // to 0x80000000 with a zero remainder.
  assign dvd_neg  = (op == 3'd2) & rs_data[31];
  assign dvs_neg  = (op == 3'd2) & rt_data[31];
  assign dvd_mag  = dvd_neg ? (~rs_data + 32'd1) : rs_data;
  assign dvs_mag  = dvs_neg ? (~rt_data + 32'd1) : rt_data;
  assign dvs_safe = (dvs_mag == 32'd0) ? 32'd1 : dvs_mag;
  assign quo_mag  = dvd_mag / dvs_safe;
  assign rem_mag  = dvd_mag % dvs_safe;
  assign quo      = (dvd_neg ^ dvs_neg) ? (~quo_mag + 32'd1) : quo_mag;
  assign rem      = dvd_neg ? (~rem_mag + 32'd1) : rem_mag;

  always_comb begin
    result = {hi_q, lo_q};
    case (op[1:0])
      2'd0: result = $unsigned(prod_s);
      2'd1: result = prod_u;
      default: begin
        // Divide by zero leaves HI/LO as they are after the full latency.
        if (rt_data != 32'd0) result = {rem, quo};
      end
    endcase
  end

  // ---------------- state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      done_q    <= done_d;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept && is_muldiv) begin
          state_d = BUSY;
          cnt_d   = op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        end
      end
      BUSY: begin
        // Requests arriving while busy are ignored; flush cannot abort.
        if (last_cycle) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- datapath / output logic ----------------
  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_muldiv) begin
            pend_hi_d = result[63:32];
            pend_lo_d = result[31:0];
          end else if (op == 3'd4) begin
            hi_d = rs_data;
          end else if (op == 3'd5) begin
            lo_d = rs_data;
          end
        end
      end
      BUSY: begin
        if (last_cycle) begin
          hi_d   = pend_hi_q;
          lo_d   = pend_lo_q;
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign busy      = (state_q == BUSY);
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign stall_req = mult_type_id & (busy | (accept & is_muldiv));

endmodule
